clk_div_prog: RTL
=================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 14, meaning the divisor and counter width in bits (legal range 2..32).
REQ-002 SHALL have parameter DIV_RESET, default 8191, meaning the divisor loaded at reset (must be < 2^WIDTH; with defaults, square-mode output = CLK100MHZ/16384).
REQ-003 SHALL have port CLK100MHZ  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port EN  in  1  count enable; 1 = run, 0 = freeze.
REQ-006 SHALL have port MODE  in  1  output mode; 0 = tick (one-cycle pulse), 1 = square (50% duty toggle).
REQ-007 SHALL have port DIV_LOAD  in  1  one-cycle request to capture DIV_VAL as the new divisor.
REQ-008 SHALL have port DIV_VAL  in  WIDTH  new divisor D; period = D+1 input cycles.
REQ-009 SHALL have port CLK_OUT  out  1  registered square output (MODE=1).
REQ-010 SHALL have port TICK  out  1  registered one-cycle pulse per period (MODE=0).
REQ-011 SHALL have port DIV_ACK  out  1  one-cycle pulse: new divisor became active.

Function
REQ-012 SHALL hold internal registers cnt[WIDTH], div_act[WIDTH], div_pend[WIDTH], pend_v; no other state besides the outputs.
REQ-013 SHALL define "wrap" as EN=1 and cnt==div_act at a rising edge.
REQ-014 SHALL, when EN=1 and not wrap, increment cnt by 1; on wrap, set cnt to 0; arithmetic is unsigned modulo 2^WIDTH, and no other wrap path exists.
REQ-015 SHALL, when EN=0, hold cnt, CLK_OUT and div_act, and drive TICK=0 and DIV_ACK=0 on the next edge.
REQ-016 SHALL, in MODE=0, register TICK=1 for exactly the cycle after each wrap and 0 otherwise; period = div_act+1 cycles.
REQ-017 SHALL, in MODE=0, register CLK_OUT=0.
REQ-018 SHALL, in MODE=1, toggle CLK_OUT on each wrap (period 2*(div_act+1) cycles, exact 50% duty), with TICK registered 0.
REQ-019 SHALL, on a change of MODE from 0 to 1, start CLK_OUT from 0, with the first toggle at the next wrap; cnt SHALL NOT be reset by a mode change.
REQ-020 SHALL, on DIV_LOAD=1 at a non-wrap edge, set div_pend<=DIV_VAL and pend_v<=1; a later load before the wrap overwrites it (last wins), and only one DIV_ACK is produced.
REQ-021 SHALL, on wrap, load div_act from DIV_VAL if DIV_LOAD=1 at that edge, else from div_pend if pend_v=1; in either case it clears pend_v and registers DIV_ACK=1 for one cycle.
REQ-022 SHALL apply divisor changes only at wrap, so no output period is truncated or stretched mid-period (glitch-free).
REQ-023 SHALL, with EN=0, still capture loads into div_pend; application waits for the first wrap after EN returns to 1.
REQ-024 SHALL treat D=0 as legal: wrap every cycle; TICK constantly 1 in MODE=0; CLK_OUT toggles every cycle (div-by-2) in MODE=1.
REQ-025 SHALL treat D=2^WIDTH-1 as legal: period 2^WIDTH cycles; cnt never overflows past div_act.

Reset
REQ-026 SHALL, while RST=1 (asynchronously, independent of clock), force cnt=0, div_act=DIV_RESET, div_pend=0, pend_v=0, CLK_OUT=0, TICK=0, DIV_ACK=0.
REQ-027 SHALL discard any pending load on reset mid-period; after RST deasserts, the first wrap occurs DIV_RESET+1 enabled cycles later.

Verification
REQ-028 SHALL cover defaults, EN=1, MODE=1 after reset -> CLK_OUT rises after 8192 cycles, period 16384, high time 8192.
REQ-029 SHALL cover MODE=0, DIV_LOAD with DIV_VAL=4 mid-period -> the current period completes unchanged, DIV_ACK 1 cycle after that wrap, then TICK every 5 cycles.
REQ-030 SHALL cover DIV_VAL=0 loaded, MODE=1 -> after ACK, CLK_OUT toggles every cycle; MODE=0 -> TICK held 1.
REQ-031 SHALL cover two loads (3 then 9) before one wrap -> a single DIV_ACK, and the new period is 10 cycles.
REQ-032 SHALL cover EN=0 for 20 cycles mid-count with a load of 2 -> cnt/CLK_OUT frozen, TICK=0, no ACK; after EN=1 the old period finishes, then ACK and period 3.
REQ-033 SHALL cover RST pulsed between clock edges with a pending load -> outputs 0 immediately, pend_v=0, and the next period uses DIV_RESET.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable clock divider with tick or 50%-duty square output.
// A new divisor is applied only at a period boundary, so no output period is cut short or stretched.
module clk_div_prog #(
    parameter int unsigned WIDTH     = 14,
    parameter int unsigned DIV_RESET = 8191
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    input  logic             EN,
    input  logic             MODE,
    input  logic             DIV_LOAD,
    input  logic [WIDTH-1:0] DIV_VAL,
    output logic             CLK_OUT,
    output logic             TICK,
    output logic             DIV_ACK
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    logic             pend_v_q, pend_v_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             wrap;

    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_v_d   = pend_v_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        ack_d      = 1'b0;

        wrap = EN && (cnt_q == div_act_q);

        if (EN) begin
            cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
        end

        // Tick mode parks the square output low, so a switch to square mode starts from 0.
        if (!MODE) begin
            clk_out_d = 1'b0;
        end else if (wrap) begin
            clk_out_d = ~clk_out_q;
        end

        tick_d = wrap && !MODE;

        // A load on the wrap edge itself takes priority over an older pending one.
        if (wrap) begin
            if (DIV_LOAD) begin
                div_act_d = DIV_VAL;
                pend_v_d  = 1'b0;
                ack_d     = 1'b1;
            end else if (pend_v_q) begin
                div_act_d = div_pend_q;
                pend_v_d  = 1'b0;
                ack_d     = 1'b1;
            end
        end else if (DIV_LOAD) begin
            div_pend_d = DIV_VAL;
            pend_v_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            cnt_q      <= '0;
            div_act_q  <= WIDTH'(DIV_RESET);
            div_pend_q <= '0;
            pend_v_q   <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_v_q   <= pend_v_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
        end
    end

    assign CLK_OUT = clk_out_q;
    assign TICK    = tick_q;
    assign DIV_ACK = ack_q;

endmodule
